codificador_16a4: RTL and testbench
===================================

CODIFICADOR_16A4 -- requirements
Module: codificador_16a4

Interface
REQ-001 SHALL provide parameter: PRIORIDAD_ALTA, default 0, arbitration order (0 = lowest index served first, 1 = highest index served first).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous assert, active-low; the block uses only this one clock and this one reset.
REQ-004 SHALL provide port: habilitar  input  1  enable; when 0, solicitud is ignored.
REQ-005 SHALL provide port: solicitud  input  16  request bits, multi-hot allowed, sampled every edge while habilitar=1.
REQ-006 SHALL provide port: listo  input  1  downstream ready.
REQ-007 SHALL provide port: codigo  output  4  registered binary index of the presented request.
REQ-008 SHALL provide port: valido  output  1  registered; codigo is meaningful when 1.
REQ-009 SHALL provide port: pendientes  output  16  registered pending-request vector P, excluding the bit currently presented.
REQ-010 SHALL provide port: ninguno  output  1  1 when P==0 and valido==0.
REQ-011 SHALL provide port: desborde  output  1  sticky overflow flag.

Function
REQ-012 SHALL update P each edge: P <= (P & ~C) | (habilitar ? solicitud : 0), where C is the one-hot bit loaded into the output stage that edge, or 0 if none is loaded.
REQ-013 SHALL implement a two-state output FSM: VACIO (valido=0) and PRESENTANDO (valido=1).
REQ-014 SHALL, in VACIO with P!=0, load codigo=enc(P), set C=onehot(codigo), and go to PRESENTANDO.
REQ-015 SHALL, in PRESENTANDO with listo=1 and P!=0, load the next enc(P) back-to-back, staying in PRESENTANDO with no bubble.
REQ-016 SHALL, in PRESENTANDO with listo=1 and P==0, go to VACIO with valido=0 and codigo holding its last value.
REQ-017 SHALL, in PRESENTANDO with listo=0, hold codigo and valido stable and set C=0.
REQ-018 SHALL compute enc(P) as the lowest set index when PRIORIDAD_ALTA=0 and the highest set index when PRIORIDAD_ALTA=1.
REQ-019 SHALL have latency: a request sampled at edge k appears in P after edge k, and can be presented no earlier than after edge k+1.
REQ-020 SHALL, when a new request bit equals the bit being cleared (C) in the same edge, keep that bit set in P and not raise desborde.
REQ-021 SHALL, when a new request bit is already set in P and is not being cleared that edge, set desborde=1 and leave P unchanged for that bit (requests do not count).
REQ-022 SHALL place a new request for the index currently held in codigo into P as a fresh request, without raising desborde.
REQ-023 SHALL keep desborde at 1 until reset once it is set.
REQ-024 SHALL, with habilitar=0, ignore solicitud while draining of P and of the output stage continues unchanged.
REQ-025 SHALL derive ninguno combinationally from the registered P and valido.

Reset
REQ-026 SHALL, on rst_n=0 and immediately without waiting for a clock edge, force valido=0, codigo=0, P=0 (pendientes=0), desborde=0, and FSM=VACIO; ninguno then reads 1.
REQ-027 SHALL, on reset mid-operation, discard all pending and presented requests, with no request surviving reset.
REQ-028 SHALL, after rst_n deasserts, update state on the first rising edge.

Verification
REQ-029 SHALL cover: assert rst_n=0 mid-cycle while valido=1 and P=0x00F0 -> valido=0, codigo=0, pendientes=0, ninguno=1, desborde=0 before the next edge.
REQ-030 SHALL cover: solicitud=0x0008 for one cycle with listo=1 -> after edge 1 pendientes=0x0008; after edge 2 valido=1, codigo=3, pendientes=0; after edge 3 valido=0, ninguno=1.
REQ-031 SHALL cover: solicitud=0x8421 for one cycle with listo=1 -> codigo sequence 0,5,10,15 on consecutive cycles then valido=0 (PRIORIDAD_ALTA=0); with PRIORIDAD_ALTA=1 the sequence is 15,10,5,0.
REQ-032 SHALL cover: listo=0 and solicitud=0x0006 -> codigo=1, valido=1 held for N cycles, pendientes=0x0004; then listo=1 -> codigo=2 on the next cycle, then valido=0.
REQ-033 SHALL cover: listo=0, solicitud=0x0003, then one idle cycle, then solicitud=0x0002 -> desborde=1 after the third edge, pendientes=0x0002, and desborde stays 1 until rst_n=0.
REQ-034 SHALL cover: habilitar=0 with solicitud=0xFFFF for 5 cycles from reset -> pendientes=0, valido=0, ninguno=1 throughout.

Source files
------------

// File: rtl/codificador_16a4.sv
// Priority encoder for 16 multi-hot request bits with a pending-request vector,
// a two-state registered output stage with valid/ready handshake, and a sticky overflow flag.
module codificador_16a4 #(
  parameter bit PRIORIDAD_ALTA = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        habilitar,
  input  logic [15:0] solicitud,
  input  logic        listo,
  output logic [3:0]  codigo,
  output logic        valido,
  output logic [15:0] pendientes,
  output logic        ninguno,
  output logic        desborde
);

  typedef enum logic {
    VACIO       = 1'b0,
    PRESENTANDO = 1'b1
  } estado_t;

  estado_t     estadoR, estadoS;
  logic [15:0] pendR, pendS;
  logic [15:0] cargaS;
  logic [15:0] nuevoS;
  logic [3:0]  codigoR, codigoS;
  logic        desbordeR, desbordeS;
  logic        cargarS;

  // Index selection: later loop iterations win, so the scan direction sets the priority.
  function automatic logic [3:0] codificar(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    if (PRIORIDAD_ALTA) begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) idx = 4'(i);
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (v[i]) idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Output-stage next state: decides whether a new index is loaded this edge.
  always_comb begin
    estadoS = estadoR;
    cargarS = 1'b0;
    case (estadoR)
      VACIO: begin
        if (pendR != 16'h0000) begin
          cargarS = 1'b1;
          estadoS = PRESENTANDO;
        end else begin
          estadoS = VACIO;
        end
      end
      PRESENTANDO: begin
        if (listo) begin
          if (pendR != 16'h0000) begin
            cargarS = 1'b1;
          end else begin
            estadoS = VACIO;
          end
        end else begin
          cargarS = 1'b0;
        end
      end
      default: begin
        estadoS = VACIO;
        cargarS = 1'b0;
      end
    endcase
  end

  // Pending vector and overflow update; a bit being cleared this edge may be re-requested freely.
  always_comb begin
    codigoS = codigoR;
    cargaS  = 16'h0000;
    if (cargarS) begin
      codigoS = codificar(pendR);
      cargaS  = 16'h0001 << codigoS;
    end else begin
      codigoS = codigoR;
      cargaS  = 16'h0000;
    end
    nuevoS    = habilitar ? solicitud : 16'h0000;
    pendS     = (pendR & ~cargaS) | nuevoS;
    desbordeS = desbordeR | (|(nuevoS & pendR & ~cargaS));
  end

  // State, output and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estadoR   <= VACIO;
      pendR     <= 16'h0000;
      codigoR   <= 4'd0;
      desbordeR <= 1'b0;
    end else begin
      estadoR   <= estadoS;
      pendR     <= pendS;
      codigoR   <= codigoS;
      desbordeR <= desbordeS;
    end
  end

  assign codigo     = codigoR;
  assign valido     = (estadoR == PRESENTANDO);
  assign pendientes = pendR;
  assign desborde   = desbordeR;
  assign ninguno    = (pendR == 16'h0000) && (estadoR == VACIO);

endmodule

// File: tb/tb_codificador_16a4.sv
// Scoreboard bench: two instances (low and high priority) share stimulus; a monitor
// pops expected codes on every accepted transfer while directed checks cover the rest.
module tb_codificador_16a4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        habilitar;
  logic [15:0] solicitud;
  logic        listo;
  logic [3:0]  codigo0, codigo1;
  logic        valido0, valido1;
  logic [15:0] pend0, pend1;
  logic        ninguno0, ninguno1;
  logic        desborde0, desborde1;

  int total = 0;
  int bad   = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] seqBaja[4] = '{4'd0, 4'd5, 4'd10, 4'd15};
  logic [3:0] seqAlta[4] = '{4'd15, 4'd10, 4'd5, 4'd0};

  codificador_16a4 #(.PRIORIDAD_ALTA(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .solicitud(solicitud), .listo(listo),
    .codigo(codigo0), .valido(valido0), .pendientes(pend0), .ninguno(ninguno0), .desborde(desborde0)
  );

  codificador_16a4 #(.PRIORIDAD_ALTA(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .solicitud(solicitud), .listo(listo),
    .codigo(codigo1), .valido(valido1), .pendientes(pend1), .ninguno(ninguno1), .desborde(desborde1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the low-priority instance: a transfer is valido && listo at the next edge.
  always @(negedge clk) begin
    if (rst_n && valido0 && listo) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon0_extra actual=%0h required=none", codigo0);
      end else begin
        chk("mon0_codigo", {28'h0, codigo0}, {28'h0, q0.pop_front()});
      end
    end
  end

  // Monitor for the high-priority instance.
  always @(negedge clk) begin
    if (rst_n && valido1 && listo) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon1_extra actual=%0h required=none", codigo1);
      end else begin
        chk("mon1_codigo", {28'h0, codigo1}, {28'h0, q1.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; habilitar = 1'b0; solicitud = 16'h0000; listo = 1'b0;
    #1;
    chk("rst_valido", {31'h0, valido0}, 32'h0);
    chk("rst_ninguno", {31'h0, ninguno0}, 32'h1);
    chk("rst_pend", {16'h0, pend0}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Disabled requests are ignored.
    habilitar = 1'b0; solicitud = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("dis_pend0", {16'h0, pend0}, 32'h0);
      chk("dis_pend1", {16'h0, pend1}, 32'h0);
      chk("dis_valido", {31'h0, valido0}, 32'h0);
      chk("dis_ninguno", {31'h0, ninguno0}, 32'h1);
    end

    // Single request latency.
    habilitar = 1'b1; listo = 1'b1; solicitud = 16'h0008;
    q0.push_back(4'd3); q1.push_back(4'd3);
    cyc(); solicitud = 16'h0000;
    chk("lat_pend_e1", {16'h0, pend0}, 32'h8);
    chk("lat_valido_e1", {31'h0, valido0}, 32'h0);
    cyc();
    chk("lat_valido_e2", {31'h0, valido0}, 32'h1);
    chk("lat_codigo_e2", {28'h0, codigo0}, 32'h3);
    chk("lat_pend_e2", {16'h0, pend0}, 32'h0);
    cyc();
    chk("lat_valido_e3", {31'h0, valido0}, 32'h0);
    chk("lat_ninguno_e3", {31'h0, ninguno0}, 32'h1);

    // Multi-hot, back-to-back in both priority orders.
    solicitud = 16'h8421;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(seqBaja[i]); q1.push_back(seqAlta[i]);
    end
    cyc(); solicitud = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("seq_codigo0", {28'h0, codigo0}, {28'h0, seqBaja[i]});
      chk("seq_codigo1", {28'h0, codigo1}, {28'h0, seqAlta[i]});
      chk("seq_valido0", {31'h0, valido0}, 32'h1);
    end
    cyc();
    chk("seq_end0", {31'h0, valido0}, 32'h0);
    chk("seq_end1", {31'h0, valido1}, 32'h0);

    // Re-request of the bit being cleared is kept without overflow.
    solicitud = 16'h0001;
    q0.push_back(4'd0); q0.push_back(4'd0);
    q1.push_back(4'd0); q1.push_back(4'd0);
    cyc(); cyc(); solicitud = 16'h0000;
    chk("clr_pend", {16'h0, pend0}, 32'h1);
    chk("clr_desb", {31'h0, desborde0}, 32'h0);
    cyc(); cyc();
    chk("clr_end", {31'h0, valido0}, 32'h0);

    // Backpressure holds the output stage.
    listo = 1'b0; solicitud = 16'h0006;
    q0.push_back(4'd1); q0.push_back(4'd2);
    q1.push_back(4'd2); q1.push_back(4'd1);
    cyc(); solicitud = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hold_codigo0", {28'h0, codigo0}, 32'h1);
      chk("hold_valido0", {31'h0, valido0}, 32'h1);
      chk("hold_pend0", {16'h0, pend0}, 32'h4);
      chk("hold_codigo1", {28'h0, codigo1}, 32'h2);
      chk("hold_pend1", {16'h0, pend1}, 32'h2);
    end
    listo = 1'b1;
    cyc();
    chk("rel_codigo0", {28'h0, codigo0}, 32'h2);
    chk("rel_codigo1", {28'h0, codigo1}, 32'h1);
    chk("rel_pend0", {16'h0, pend0}, 32'h0);
    cyc();
    chk("rel_end0", {31'h0, valido0}, 32'h0);
    chk("rel_end1", {31'h0, valido1}, 32'h0);

    // Asynchronous reset mid-operation.
    listo = 1'b0; solicitud = 16'h0001;
    cyc(); solicitud = 16'h00F0;
    cyc(); solicitud = 16'h0000;
    chk("pre_rst_pend", {16'h0, pend0}, 32'hF0);
    chk("pre_rst_valido", {31'h0, valido0}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valido", {31'h0, valido0}, 32'h0);
    chk("arst_codigo", {28'h0, codigo0}, 32'h0);
    chk("arst_pend0", {16'h0, pend0}, 32'h0);
    chk("arst_pend1", {16'h0, pend1}, 32'h0);
    chk("arst_ninguno", {31'h0, ninguno0}, 32'h1);
    chk("arst_desb", {31'h0, desborde0}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_valido", {31'h0, valido0}, 32'h0);
    chk("post_rst_ninguno", {31'h0, ninguno0}, 32'h1);

    // Overflow on an already-pending bit; the presented index is a fresh request.
    listo = 1'b0; solicitud = 16'h0003;
    cyc(); solicitud = 16'h0000;
    cyc(); solicitud = 16'h0002;
    cyc(); solicitud = 16'h0000;
    chk("ovf_desb0", {31'h0, desborde0}, 32'h1);
    chk("ovf_pend0", {16'h0, pend0}, 32'h2);
    chk("ovf_desb1", {31'h0, desborde1}, 32'h0);
    chk("ovf_pend1", {16'h0, pend1}, 32'h3);
    repeat (3) cyc();
    chk("ovf_sticky", {31'h0, desborde0}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ovf_rst", {31'h0, desborde0}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();

    chk("q0_empty", q0.size(), 32'h0);
    chk("q1_empty", q1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
